des_output_unit: RTL and testbench
==================================

# des_output_unit

Final stage of the DES datapath. Accepts the 64-bit round-16 result (L16‖R16) over a valid/ready handshake, applies the 32-bit half swap and the final permutation FP (the inverse of IP), and buffers results in a small FIFO. Each ciphertext block leaves as two 32-bit words on a valid/ready word stream toward the bus bridge.

## Interface
- DEPTH, 2: FIFO depth in 64-bit blocks; power of two, ≥2.
- LSW_FIRST, 0: 0 emits ct[0:31] first; 1 emits ct[32:63] first.

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  in_block valid
- in_ready  out  1  unit can accept a block
- in_block  in  [0:63]  L16 in [0:31], R16 in [32:63]; bit 0 = MSB
- out_valid  out  1  out_word valid
- out_ready  in  1  sink accepts out_word
- out_word  out  [0:31]  ciphertext word
- out_last  out  1  high on second word of a block
- busy  out  1  FIFO non-empty or serializer not idle
- chk_err  out  1  sticky self-check failure; tied 0 without macro

## Operation
- Push on in_valid && in_ready: pre = {R16, L16}; ct[i] = pre[FP(i)]. For row r = 0..7, ct[8r..8r+7] takes pre indices 39−r, 7−r, 47−r, 15−r, 55−r, 23−r, 63−r, 31−r (0-based). ct is written to the FIFO.
- in_ready = (count < DEPTH), from registered count only. No combinational path from out_ready.
- in_block is ignored when in_valid is low.
- Serializer FSM has states S_IDLE, S_W0, S_W1.
  - S_IDLE: if FIFO non-empty, pop into 64-bit out_reg, go to S_W0.
  - S_W0: out_valid=1, first word, out_last=0. On out_ready go to S_W1.
  - S_W1: out_valid=1, second word, out_last=1. On out_ready: if FIFO non-empty, pop and go to S_W0; else go to S_IDLE.
- out_word, out_last and out_valid are registered. They stay stable while out_valid && !out_ready.
- Push and pop in the same cycle: count unchanged; both complete. When full, in_ready stays 0 during the popping cycle and rises the next cycle.
- Pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.

## Timing
- Reset values: out_valid=0, out_word=0, out_last=0, busy=0, chk_err=0. FIFO is emptied and FSM goes to S_IDLE. in_ready=1 once count=0.
- Reset asserted mid-block discards all buffered and partially sent blocks. No word is emitted after reset deasserts until a new push.
- Latency: a block accepted at edge k with FIFO empty and FSM idle gives word0 valid after edge k+1.
- Sustained throughput: one block per 2 cycles with out_ready held high. No idle cycle between blocks when the FIFO is non-empty.
- A full FIFO with out_ready low holds indefinitely. Nothing is dropped or overwritten.

## Configuration
- DES_FP_SELFCHK_EN defined: on each push, compute IP(ct) and compare to pre. On mismatch, set chk_err on the next edge; it clears only on reset. Push timing is unaffected.
- Undefined: no check logic is built; chk_err is constant 0.

## Structure
- des_pkg holds:
  - DES_BLOCK_W=64 and DES_WORD_W=32
  - FP and IP index tables as localparam arrays
  - typedef enum for the serializer state {S_IDLE, S_W0, S_W1}
- Sub-module des_final_permutation: purely combinational [0:63]→[0:63] wiring from the package FP table. Reused by the decrypt path.
- FIFO and FSM live inline in des_output_unit.

## Test plan
- Known vector. Push in_block=43423234_0A4CD995 with out_ready=1 → words 85E81354 then 0F0AB405, out_last on the second. Repeat with LSW_FIRST=1: order reverses.
- Back-to-back: 4 pushes on consecutive cycles, DEPTH=2, out_ready=1 → in_ready drops while full. 8 words emitted in order on contiguous cycles after the first.
- Backpressure: fill FIFO, hold out_ready=0 for 20 cycles → out_word, out_last and out_valid stay constant, in_ready=0. Release → all blocks delivered intact.
- Simultaneous push and pop at full → count unchanged, no loss or duplication. Scoreboard matches for 1000 random blocks with random valid/ready.
- Reset mid-block: drop n_rst after word0 has been accepted → outputs return to reset values at once. After release, no stale word1 appears and busy=0.
- DES_FP_SELFCHK_EN: normal traffic keeps chk_err=0. Force a stuck bit in the FP path → chk_err=1 and sticky until n_rst.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES definitions: datapath widths, FP/IP index tables, serializer states.
package des_pkg;

  localparam int unsigned DES_BLOCK_W = 64;
  localparam int unsigned DES_WORD_W  = 32;

  // Final permutation: ct[i] = pre[FP_TAB[i]], 0-based, bit 0 = MSB.
  localparam int unsigned FP_TAB [DES_BLOCK_W] = '{
    39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,
    37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,
    35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,
    33,  1, 41,  9, 49, 17, 57, 25,
    32,  0, 40,  8, 48, 16, 56, 24
  };

  // Initial permutation (inverse of FP): y[i] = x[IP_TAB[i]].
  localparam int unsigned IP_TAB [DES_BLOCK_W] = '{
    57, 49, 41, 33, 25, 17,  9,  1,
    59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,
    63, 55, 47, 39, 31, 23, 15,  7,
    56, 48, 40, 32, 24, 16,  8,  0,
    58, 50, 42, 34, 26, 18, 10,  2,
    60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6
  };

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_W0   = 2'd1,
    S_W1   = 2'd2
  } ser_state_t;

endpackage

// File: rtl/des_final_permutation.sv
// DES final permutation FP: pure wiring from the package table (shared with decrypt path).
module des_final_permutation
  import des_pkg::*;
(
  input  logic [0:DES_BLOCK_W-1] pre,
  output logic [0:DES_BLOCK_W-1] ct
);

  // One wire per output bit, routed from the FP table.
  for (genvar i = 0; i < DES_BLOCK_W; i++) begin : g_fp
    assign ct[i] = pre[FP_TAB[i]];
  end

endmodule

// File: rtl/des_output_unit.sv
// DES output stage: half swap + FP, block FIFO, two-word serializer.
// Optional FP self-check (IP(ct) == pre) built when DES_FP_SELFCHK_EN is defined.
module des_output_unit
  import des_pkg::*;
#(
  parameter int unsigned DEPTH     = 2,
  parameter bit          LSW_FIRST = 1'b0
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [0:DES_BLOCK_W-1]  in_block,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [0:DES_WORD_W-1]   out_word,
  output logic                    out_last,
  output logic                    busy,
  output logic                    chk_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [0:DES_BLOCK_W-1] pre;
  logic [0:DES_BLOCK_W-1] ct;
  logic [0:DES_BLOCK_W-1] mem [DEPTH];
  logic [0:DES_BLOCK_W-1] rd_data;
  logic [0:DES_WORD_W-1]  rd_first_c;
  logic [0:DES_WORD_W-1]  rd_second_c;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       count_nxt;
  logic                   push_c;
  logic                   pop_c;
  logic                   fifo_ne_c;

  ser_state_t             state;
  ser_state_t             state_nxt;
  logic [0:DES_WORD_W-1]  word1;
  logic [0:DES_WORD_W-1]  word1_nxt;
  logic [0:DES_WORD_W-1]  out_word_nxt;
  logic                   out_valid_nxt;
  logic                   out_last_nxt;

  // Round-16 output is {L16, R16}; FP operates on the swapped {R16, L16}.
  assign pre = {in_block[DES_WORD_W:DES_BLOCK_W-1], in_block[0:DES_WORD_W-1]};

  des_final_permutation u_fp (
    .pre (pre),
    .ct  (ct)
  );

  assign push_c    = in_valid && in_ready;
  assign fifo_ne_c = (count != '0);
  assign rd_data   = mem[rd_ptr];

  // Word order of the block at the FIFO head.
  assign rd_first_c  = LSW_FIRST ? rd_data[DES_WORD_W:DES_BLOCK_W-1] : rd_data[0:DES_WORD_W-1];
  assign rd_second_c = LSW_FIRST ? rd_data[0:DES_WORD_W-1] : rd_data[DES_WORD_W:DES_BLOCK_W-1];

  // FIFO storage; contents need no reset since occupancy lives in count.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= ct;
    end
  end

  // Occupancy for simultaneous push/pop.
  always_comb begin
    count_nxt = count;
    if (push_c && !pop_c) begin
      count_nxt = count + CNT_W'(1);
    end else if (!push_c && pop_c) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  // FIFO pointers, count and registered in_ready.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b1;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count    <= count_nxt;
      in_ready <= (count_nxt < CNT_W'(DEPTH));
    end
  end

  // Serializer next state, FIFO pop and next output values.
  always_comb begin
    state_nxt     = state;
    pop_c         = 1'b0;
    word1_nxt     = word1;
    out_valid_nxt = out_valid;
    out_word_nxt  = out_word;
    out_last_nxt  = out_last;
    unique case (state)
      S_IDLE: begin
        if (fifo_ne_c) begin
          pop_c         = 1'b1;
          state_nxt     = S_W0;
          out_valid_nxt = 1'b1;
          out_word_nxt  = rd_first_c;
          out_last_nxt  = 1'b0;
          word1_nxt     = rd_second_c;
        end
      end
      S_W0: begin
        if (out_ready) begin
          state_nxt    = S_W1;
          out_word_nxt = word1;
          out_last_nxt = 1'b1;
        end
      end
      S_W1: begin
        if (out_ready) begin
          if (fifo_ne_c) begin
            pop_c         = 1'b1;
            state_nxt     = S_W0;
            out_valid_nxt = 1'b1;
            out_word_nxt  = rd_first_c;
            out_last_nxt  = 1'b0;
            word1_nxt     = rd_second_c;
          end else begin
            state_nxt     = S_IDLE;
            out_valid_nxt = 1'b0;
            out_last_nxt  = 1'b0;
          end
        end
      end
      default: begin
        state_nxt     = S_IDLE;
        out_valid_nxt = 1'b0;
        out_last_nxt  = 1'b0;
      end
    endcase
  end

  // Serializer state and registered output stream.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= S_IDLE;
      word1     <= '0;
      out_valid <= 1'b0;
      out_word  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      word1     <= word1_nxt;
      out_valid <= out_valid_nxt;
      out_word  <= out_word_nxt;
      out_last  <= out_last_nxt;
      busy      <= (count_nxt != '0) || (state_nxt != S_IDLE);
    end
  end

`ifdef DES_FP_SELFCHK_EN
  logic [0:DES_BLOCK_W-1] ip_c;

  // IP undoes FP, so IP(ct) must reproduce the swapped input.
  for (genvar i = 0; i < DES_BLOCK_W; i++) begin : g_ip
    assign ip_c[i] = ct[IP_TAB[i]];
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      chk_err <= 1'b0;
    end else if (push_c && (ip_c != pre)) begin
      chk_err <= 1'b1;
    end
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_output_unit.sv
// Self-checking bench for des_output_unit (MSW-first and LSW-first instances side by side).
module tb_des_output_unit;

  logic        clk;
  logic        n_rst;
  logic        in_valid;
  logic        in_ready, in_ready2;
  logic [63:0] in_block;
  logic        out_valid, out_valid2;
  logic        out_ready;
  logic [31:0] out_word, out_word2;
  logic        out_last, out_last2;
  logic        busy, busy2;
  logic        chk_err, chk_err2;

  des_output_unit #(.DEPTH(2), .LSW_FIRST(1'b0)) u_dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_last(out_last), .busy(busy), .chk_err(chk_err)
  );

  des_output_unit #(.DEPTH(2), .LSW_FIRST(1'b1)) u_dut_lsw (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_block(in_block), .out_valid(out_valid2), .out_ready(out_ready),
    .out_word(out_word2), .out_last(out_last2), .busy(busy2), .chk_err(chk_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] blk;
    logic [63:0] ct;
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [63:0] sb [$];
  logic [63:0] cur_exp;
  bit          half;
  bit          acc;
  bit          saw_stall;
  int          hs_count, hs_first, hs_last;

  // Reference FP written from the row rule: pre indices 39-r,7-r,47-r,15-r,...
  function automatic logic [63:0] fp_model(input logic [63:0] blk);
    logic [0:63] b, pre, ct;
    logic [5:0]  idx, pos;
    b   = blk;
    pre = {b[32:63], b[0:31]};
    ct  = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        idx = 6'((((c % 2) == 0) ? (39 + 4 * c) : (3 + 4 * c)) - r);
        pos = 6'(8 * r + c);
        ct[pos] = pre[idx];
      end
    end
    return ct;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Observes handshakes in the middle of the cycle; scoreboard push/pop/compare.
  task automatic monitor();
    logic [63:0] e;
    cyc++;
    acc = 1'b0;
    if (!n_rst) begin
      sb.delete();
      half = 1'b0;
      return;
    end
    if (in_valid && !in_ready) saw_stall = 1'b1;
    if (out_valid && out_ready) begin
      hs_count++;
      if (hs_count == 1) hs_first = cyc;
      hs_last = cyc;
      if (sb.size() == 0) begin
        chk("unexpected_word", 64'(out_word), 64'hX);
      end else begin
        e = sb[0];
        chk("word", 64'(out_word), half ? 64'(e[31:0]) : 64'(e[63:32]));
        chk("last", 64'(out_last), 64'(half));
        chk("valid_lsw", 64'(out_valid2), 64'd1);
        chk("word_lsw", 64'(out_word2), half ? 64'(e[63:32]) : 64'(e[31:0]));
        chk("last_lsw", 64'(out_last2), 64'(half));
        if (half) void'(sb.pop_front());
        half = ~half;
      end
    end
    if (in_valid && in_ready) begin
      chk("in_ready_lsw", 64'(in_ready2), 64'd1);
      sb.push_back(cur_exp);
      acc = 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic push_block(input logic [63:0] blk, input logic [63:0] exp);
    in_valid = 1'b1;
    in_block = blk;
    cur_exp  = exp;
    for (int t = 0; t < 300; t++) begin
      step();
      if (acc) break;
    end
    if (!acc) chk("push_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
    in_block = {$urandom, $urandom};
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 300; t++) begin
      if (sb.size() == 0 && !out_valid && !busy) begin
        done = 1'b1;
        break;
      end
      step();
    end
    chk("drain_done", 64'(done), 64'd1);
  endtask

  vec_t        vecs [6];
  logic [31:0] snap_word;
  logic        snap_last, snap_valid;
  int          pushed;
  bit          stale;
  logic [63:0] rb;

  initial begin
    vecs[0] = '{blk: 64'h43423234_0A4CD995, ct: 64'h85E81354_0F0AB405};
    vecs[1] = '{blk: 64'h00000000_00000000, ct: 64'h00000000_00000000};
    vecs[2] = '{blk: 64'hFFFFFFFF_FFFFFFFF, ct: 64'hFFFFFFFF_FFFFFFFF};
    vecs[3] = '{blk: 64'h80000000_00000000, ct: 64'h00000000_00000080};
    vecs[4] = '{blk: 64'h00000000_00000001, ct: 64'h01000000_00000000};
    vecs[5] = '{blk: 64'h00000000_FFFFFFFF, ct: 64'h55555555_55555555};

    n_rst = 1'b0; in_valid = 1'b0; in_block = '0; out_ready = 1'b0;
    cur_exp = '0; half = 1'b0; saw_stall = 1'b0;
    hs_count = 0; hs_first = 0; hs_last = 0;

    // Reset state
    repeat (3) step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_word", 64'(out_word), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_chk_err", 64'(chk_err), 64'd0);
    n_rst = 1'b1;
    step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Latency and known vector, step by step
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_block  = vecs[0].blk;
    cur_exp   = vecs[0].ct;
    step();
    chk("lat_accept", 64'(acc), 64'd1);
    in_valid = 1'b0;
    chk("lat_k_valid", 64'(out_valid), 64'd0);
    chk("lat_k_busy", 64'(busy), 64'd1);
    step();
    chk("lat_k1_valid", 64'(out_valid), 64'd1);
    chk("kv_word0", 64'(out_word), 64'h85E81354);
    chk("kv_last0", 64'(out_last), 64'd0);
    chk("kv_lsw_word0", 64'(out_word2), 64'h0F0AB405);
    step();
    chk("kv_word1", 64'(out_word), 64'h0F0AB405);
    chk("kv_last1", 64'(out_last), 64'd1);
    chk("kv_lsw_word1", 64'(out_word2), 64'h85E81354);
    step();
    chk("kv_idle_valid", 64'(out_valid), 64'd0);
    chk("kv_idle_busy", 64'(busy), 64'd0);

    // Table-driven vectors through the scoreboard
    for (int i = 0; i < 6; i++) begin
      push_block(vecs[i].blk, vecs[i].ct);
      drain();
    end

    // Back-to-back pushes: stall while full, 8 contiguous words
    hs_count = 0; saw_stall = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rb = {$urandom, $urandom};
      in_valid = 1'b1;
      in_block = rb;
      cur_exp  = fp_model(rb);
      for (int t = 0; t < 50; t++) begin
        step();
        if (acc) break;
      end
      if (!acc) chk("b2b_push_timeout", 64'd0, 64'd1);
    end
    in_valid = 1'b0;
    drain();
    chk("b2b_stall_seen", 64'(saw_stall), 64'd1);
    chk("b2b_words", 64'(hs_count), 64'd8);
    chk("b2b_contiguous", 64'(hs_last - hs_first), 64'd7);

    // Backpressure: fill, hold 20 cycles, then release
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rb = {$urandom, $urandom};
      push_block(rb, fp_model(rb));
    end
    step();
    chk("bp_full", 64'(in_ready), 64'd0);
    chk("bp_valid", 64'(out_valid), 64'd1);
    snap_word = out_word; snap_last = out_last; snap_valid = out_valid;
    rb = {$urandom, $urandom};
    in_valid = 1'b1; in_block = rb; cur_exp = fp_model(rb);
    for (int t = 0; t < 20; t++) begin
      step();
      chk("bp_hold_word", 64'(out_word), 64'(snap_word));
      chk("bp_hold_last", 64'(out_last), 64'(snap_last));
      chk("bp_hold_valid", 64'(out_valid), 64'(snap_valid));
      chk("bp_hold_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    push_block(rb, fp_model(rb));
    drain();

    // Random traffic with random valid/ready
    pushed = 0;
    for (int t = 0; t < 20000 && pushed < 1000; t++) begin
      rb        = {$urandom, $urandom};
      in_valid  = ($urandom_range(0, 9) < 7);
      in_block  = rb;
      cur_exp   = fp_model(rb);
      out_ready = ($urandom_range(0, 9) < 6);
      step();
      if (acc) pushed++;
    end
    in_valid = 1'b0;
    chk("rand_pushed", 64'(pushed), 64'd1000);
    drain();
    chk("rand_chk_err", 64'(chk_err), 64'd0);
    chk("rand_chk_err_lsw", 64'(chk_err2), 64'd0);

    // Reset after word0 accepted, with another block buffered
    out_ready = 1'b1;
    rb = {$urandom, $urandom};
    push_block(rb, fp_model(rb));
    rb = {$urandom, $urandom};
    push_block(rb, fp_model(rb));
    for (int t = 0; t < 20 && !(out_valid && out_last); t++) step();
    chk("mid_on_word1", 64'(out_valid && out_last), 64'd1);
    #2;
    n_rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_word", 64'(out_word), 64'd0);
    chk("mid_rst_last", 64'(out_last), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_busy_lsw", 64'(busy2), 64'd0);
    repeat (2) step();
    n_rst = 1'b1;
    stale = 1'b0;
    for (int t = 0; t < 10; t++) begin
      step();
      if (out_valid) stale = 1'b1;
    end
    chk("mid_no_stale", 64'(stale), 64'd0);
    chk("mid_busy_after", 64'(busy), 64'd0);
    push_block(vecs[0].blk, vecs[0].ct);
    drain();
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
